// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: splits 16-bit word accesses from two requesters into big-endian
// byte accesses on the byte-wide data memory, arbitrating fixed or round-robin.
module data_mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        busy,
    output logic        mem_we,
    output logic        mem_re,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    typedef enum logic [2:0] {IDLE, ACC_HI, ACC_LO, RD_WAIT, RESP} state_t;
    state_t state, next_state;
    logic        owner, last, lat_we, grant, acc;
    logic [15:0] lat_addr, lat_wdata;
    logic [7:0]  hi;

    // last == 1 means port 1 was granted most recently
    always_comb grant = (req0 && req1) ? (FIXED_PRIO ? 1'b0 : ~last) : req1;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (req0 || req1) ? ACC_HI : IDLE;
            ACC_HI:  next_state = ACC_LO;
            ACC_LO:  next_state = lat_we ? RESP : RD_WAIT;
            RD_WAIT: next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 16'h0000;
            hi        <= 8'h00;
            rdata0    <= 16'h0000;
            rdata1    <= 16'h0000;
        end else begin
            if (state == IDLE && (req0 || req1)) begin
                owner     <= grant;
                lat_we    <= grant ? we1 : we0;
                lat_addr  <= grant ? addr1 : addr0;
                lat_wdata <= grant ? wdata1 : wdata0;
            end
            if (state == ACC_LO) hi <= mem_rdata;
            if (state != RESP && next_state == RESP) last <= owner;
            // low byte arrives in RD_WAIT; word is presented alongside done in RESP
            if (state == RD_WAIT && !owner) rdata0 <= {hi, mem_rdata};
            if (state == RD_WAIT && owner)  rdata1 <= {hi, mem_rdata};
        end
    end

    always_comb begin
        acc       = (state == ACC_HI) || (state == ACC_LO);
        busy      = state != IDLE;
        mem_we    = acc && lat_we;
        mem_re    = acc && !lat_we;
        mem_addr  = (state == ACC_LO) ? lat_addr + 16'd1 : lat_addr;
        mem_wdata = (state == ACC_LO) ? lat_wdata[7:0] : lat_wdata[15:8];
        done0     = (state == RESP) && !owner;
        done1     = (state == RESP) && owner;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed stimulus with a queue-based transaction model checked
// every cycle, plus literal expectations for latency, byte order, wrap and arbitration.
module tb_data_mem_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        done0, done1, busy, mem_we, mem_re;
    logic [15:0] rdata0, rdata1, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata = 8'h00;
    logic        fp_done0, fp_done1, fp_busy, fp_we, fp_re;
    logic [15:0] fp_rdata0, fp_rdata1, fp_addr;
    logic [7:0]  fp_wdata;

    logic [7:0]  mem [65536];
    logic [7:0]  ref_mem [65536];

    always #5 clk = ~clk;

    data_mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata));

    data_mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(fp_done0), .done1(fp_done1), .rdata0(fp_rdata0), .rdata1(fp_rdata1), .busy(fp_busy),
        .mem_we(fp_we), .mem_re(fp_re), .mem_addr(fp_addr), .mem_wdata(fp_wdata),
        .mem_rdata(8'h00));

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int checks = 0, failures = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic busy, we, re, d0, d1, rd, own;
        logic [15:0] addr;
        logic [7:0] wd;
    } ent_t;

    ent_t q[$];
    logic [15:0] exp_rd0 = 0, exp_rd1 = 0;

    function automatic ent_t mk(input logic we, re, d0, d1, rd, own, input logic [15:0] a, input logic [7:0] wd);
        ent_t r;
        r.busy = 1'b1; r.we = we; r.re = re; r.d0 = d0; r.d1 = d1; r.rd = rd; r.own = own;
        r.addr = a; r.wd = wd;
        return r;
    endfunction

    // each granted transaction becomes a list of per-cycle expected bus states
    initial begin : model
        ent_t t;
        logic last_m, g, w;
        logic [15:0] a, d, a1;
        last_m = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                q.delete();
                last_m = 1'b1;
                exp_rd0 = 16'h0000;
                exp_rd1 = 16'h0000;
            end else if (q.size() > 0) begin
                t = q.pop_front();
                if (t.we) ref_mem[t.addr] = t.wd;
            end else if (req0 || req1) begin
                g = (req0 && req1) ? (last_m ? 1'b0 : 1'b1) : req1;
                last_m = g;
                w = g ? we1 : we0;
                a = g ? addr1 : addr0;
                d = g ? wdata1 : wdata0;
                a1 = a + 16'd1;
                q.push_back(mk(w, !w, 0, 0, 0, g, a, d[15:8]));
                q.push_back(mk(w, !w, 0, 0, 0, g, a1, d[7:0]));
                if (!w) q.push_back(mk(0, 0, 0, 0, 0, g, a, 8'h00));
                q.push_back(mk(0, 0, !g, g, !w, g, a, 8'h00));
            end
            if (q.size() > 0 && q[0].rd) begin
                a1 = q[0].addr + 16'd1;
                if (q[0].own) exp_rd1 = {ref_mem[q[0].addr], ref_mem[a1]};
                else          exp_rd0 = {ref_mem[q[0].addr], ref_mem[a1]};
            end
        end
    end

    initial begin : compare
        ent_t c;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (q.size() > 0) c = q[0];
                else c = '{busy: 0, we: 0, re: 0, d0: 0, d1: 0, rd: 0, own: 0, addr: 0, wd: 0};
                chk("cyc_busy", busy, c.busy);
                chk("cyc_mem_we", mem_we, c.we);
                chk("cyc_mem_re", mem_re, c.re);
                chk("cyc_done0", done0, c.d0);
                chk("cyc_done1", done1, c.d1);
                chk("cyc_rdata0", rdata0, exp_rd0);
                chk("cyc_rdata1", rdata1, exp_rd1);
                if (c.we || c.re) chk("cyc_mem_addr", mem_addr, c.addr);
                if (c.we) chk("cyc_mem_wdata", mem_wdata, c.wd);
            end
        end
    end

    logic [23:0] wlog[$];
    logic [7:0]  seq0 = 0, seq1 = 0;
    int          n0 = 0, n1 = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mem_we) wlog.push_back({mem_addr, mem_wdata});
            if (done0 || done1) begin seq0 = {seq0[6:0], done1}; n0++; end
            if (fp_done0 || fp_done1) begin seq1 = {seq1[6:0], fp_done1}; n1++; end
        end
    end

    task automatic txn(input logic p, input logic w, input logic [15:0] a, input logic [15:0] d, output int lat);
        if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (p ? done1 : done0) lat = i;
        end
        @(posedge clk); #1;
        if (p) req1 = 0; else req0 = 0;
    endtask

    initial begin : stim
        int lat;
        #2 reset = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_rdata0", rdata0, 16'h0000);
        chk("rst_rdata1", rdata1, 16'h0000);
        chk_en = 1;
        #10 reset = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        wlog.delete();
        txn(0, 1, 16'h4312, 16'hBEEF, lat);
        chk("wr0_latency", lat, 3);
        chk("wr0_bytes", wlog.size(), 2);
        chk("wr0_hi", wlog[0], 24'h4312BE);
        chk("wr0_lo", wlog[1], 24'h4313EF);
        txn(0, 0, 16'h4312, 16'h0000, lat);
        chk("rd0_latency", lat, 4);
        chk("rd0_data", rdata0, 16'hBEEF);

        wlog.delete();
        txn(1, 1, 16'hFFFF, 16'h1234, lat);
        chk("wrap_wr_latency", lat, 3);
        chk("wrap_hi", wlog[0], 24'hFFFF12);
        chk("wrap_lo", wlog[1], 24'h000034);
        txn(1, 0, 16'hFFFF, 16'h0000, lat);
        chk("wrap_rd_latency", lat, 4);
        chk("wrap_rd_data", rdata1, 16'h1234);

        req0 = 1; we0 = 0; addr0 = 16'h4312;
        @(posedge clk); #1;
        addr0 = 16'h1111; we0 = 1; req0 = 0;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) lat = i;
        end
        chk("drop_done_latency", lat, 3);
        chk("drop_rdata0", rdata0, 16'hBEEF);
        chk("drop_rdata1", rdata1, 16'h1234);
        @(posedge clk); #1;

        req0 = 1; we0 = 1; addr0 = 16'h2000; wdata0 = 16'hA55A;
        @(posedge clk);
        @(posedge clk); #1;
        req0 = 0;
        #1 reset = 0;
        #1;
        chk("rstmid_mem_we", mem_we, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done0", done0, 0);
        #1 reset = 1;
        @(posedge clk); #1;
        txn(0, 0, 16'h2000, 16'h0000, lat);
        chk("rstmid_rd_latency", lat, 4);
        chk("rstmid_partial", rdata0, 16'hA500);

        reset = 0;
        #2 reset = 1;
        seq0 = 0; seq1 = 0; n0 = 0; n1 = 0;
        we0 = 1; addr0 = 16'h3000; wdata0 = 16'h0102;
        we1 = 1; addr1 = 16'h3010; wdata1 = 16'h0304;
        req0 = 1; req1 = 1;
        repeat (16) @(posedge clk);
        #1 req0 = 0;
        repeat (4) @(posedge clk);
        #1 req1 = 0;
        chk("rr_count", n0, 5);
        chk("rr_order", seq0[4:0], 5'b01011);
        chk("fp_count", n1, 5);
        chk("fp_order", seq1[4:0], 5'b00001);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
